// File: rtl/spi_master_shifter.sv
// SPI mode-0 master bit engine: shifts one 8-bit word MSB first on MOSI while
// capturing MISO, framed by chip select with one half-period of setup and hold.
module spi_master_shifter #(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dv_mosi,
    input  logic [7:0] data_mosi,
    output logic       ready,
    output logic       dv_miso,
    output logic [7:0] data_miso,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);

    localparam int CW = $clog2(CLKS_PER_HALF_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    edge_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic          ready_q;
    logic          dv_miso_q;
    logic [7:0]    data_miso_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          cs_n_q;
    logic          half_done_s;

    assign half_done_s = (cnt_q == HALF_LAST);

    // Transfer sequencer: every output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            edge_q      <= 4'd0;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            ready_q     <= 1'b1;
            dv_miso_q   <= 1'b0;
            data_miso_q <= 8'h00;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            dv_miso_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dv_mosi) begin
                        tx_q    <= data_mosi;
                        mosi_q  <= data_mosi[7];
                        cs_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        edge_q  <= 4'd0;
                        state_q <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (half_done_s) begin
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_done_s) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        // Even edges rise (sample MISO); odd edges fall (present next MOSI bit).
                        if (!edge_q[0]) begin
                            rx_q <= {rx_q[6:0], spi_miso};
                        end else if (edge_q != 4'd15) begin
                            tx_q   <= {tx_q[6:0], 1'b0};
                            mosi_q <= tx_q[6];
                        end
                        if (edge_q == 4'd15) begin
                            edge_q  <= 4'd0;
                            state_q <= CS_HOLD;
                        end else begin
                            edge_q <= edge_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (half_done_s) begin
                        cnt_q       <= '0;
                        cs_n_q      <= 1'b1;
                        data_miso_q <= rx_q;
                        dv_miso_q   <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign dv_miso   = dv_miso_q;
    assign data_miso = data_miso_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: a behavioural SPI slave (byte, loopback or tied-high MISO)
// checks MOSI content, MISO capture, framing and latency for H=2 and H=1 instances.
module tb_spi_master_shifter;

    localparam int H2 = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       dv2 = 1'b0;
    logic [7:0] din2 = 8'h00;
    logic       ready2, dvo2, sclk2, mosi2, csn2;
    logic [7:0] dout2;
    logic       miso2 = 1'b0;

    logic       dv1 = 1'b0;
    logic [7:0] din1 = 8'h00;
    logic       ready1, dvo1, sclk1, mosi1, csn1;
    logic [7:0] dout1;
    logic       miso1 = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    spi_master_shifter #(.CLKS_PER_HALF_BIT(H2)) u_dut2 (
        .clk(clk), .reset(reset), .dv_mosi(dv2), .data_mosi(din2),
        .ready(ready2), .dv_miso(dvo2), .data_miso(dout2),
        .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_miso(miso2), .spi_cs_n(csn2)
    );

    spi_master_shifter #(.CLKS_PER_HALF_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .dv_mosi(dv1), .data_mosi(din1),
        .ready(ready1), .dv_miso(dvo1), .data_miso(dout1),
        .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(csn1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: slave shifts out sb MSB first; mode 1: MISO = MOSI loopback; mode 2: MISO tied high.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input int mode,
                        input bit chain, input int inject_at, input int abort_at);
        int n, fall, rise, hi, cslow;
        logic [7:0] cap, exp_rx;
        logic pclk;
        bit done;
        chk("ready_before", ready2, 1);
        dv2 = 1'b1;
        din2 = tx;
        tick();
        dv2 = 1'b0;
        din2 = 8'h00;
        chk("cs_low_on_accept", csn2, 0);
        chk("ready_low_on_accept", ready2, 0);
        chk("mosi_msb_on_accept", mosi2, tx[7]);
        chk("dv_low_on_accept", dvo2, 0);
        fall = 0; rise = 0; hi = 0; cslow = 1; cap = 8'h00; pclk = 1'b0; done = 1'b0; n = 0;
        miso2 = (mode == 0) ? sb[7] : (mode == 1) ? mosi2 : 1'b1;
        while (!done && n < 18 * H2 + 4) begin
            tick();
            n++;
            if (dv2) dv2 = 1'b0;
            if (n == inject_at) begin
                dv2 = 1'b1;
                din2 = 8'hFF;
            end
            if (abort_at != 0 && n == abort_at) begin
                chk("sclk_high_at_e7", sclk2, 1);
                reset = 1'b1;
                #1;
                chk("abort_cs_n", csn2, 1);
                chk("abort_sclk", sclk2, 0);
                chk("abort_data_miso", dout2, 8'h00);
                chk("abort_ready", ready2, 1);
                chk("abort_mosi", mosi2, 0);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("abort_no_dv", dvo2, 0);
                end
                @(negedge clk);
                reset = 1'b0;
                tick();
                chk("post_release_ready", ready2, 1);
                chk("post_release_cs_n", csn2, 1);
                chk("post_release_sclk", sclk2, 0);
                chk("post_release_dv", dvo2, 0);
                return;
            end
            if (sclk2 && !pclk) begin
                rise++;
                cap = {cap[6:0], mosi2};
            end
            if (!sclk2 && pclk) fall++;
            if (sclk2) hi++;
            pclk = sclk2;
            if (dvo2) done = 1'b1;
            else if (!csn2) cslow++;
            if (mode == 0) begin
                if (fall < 8) miso2 = sb[7 - fall];
            end else if (mode == 1) begin
                miso2 = mosi2;
            end else begin
                miso2 = 1'b1;
            end
        end
        exp_rx = (mode == 0) ? sb : (mode == 1) ? tx : 8'hFF;
        chk("latency", n, 18 * H2);
        chk("data_miso", dout2, exp_rx);
        chk("mosi_word", cap, tx);
        chk("sclk_rises", rise, 8);
        chk("sclk_high_cycles", hi, 8 * H2);
        chk("cs_low_cycles", cslow, 18 * H2);
        chk("cs_high_at_done", csn2, 1);
        chk("ready_at_done", ready2, 1);
        if (!chain) begin
            tick();
            chk("dv_one_cycle", dvo2, 0);
            chk("data_miso_held", dout2, exp_rx);
        end
    endtask

    initial begin
        int n1, hi1, rise1;
        logic p1;
        bit ch;
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_ready", ready2, 1);
        chk("rst_dv", dvo2, 0);
        chk("rst_data", dout2, 8'h00);
        chk("rst_sclk", sclk2, 0);
        chk("rst_mosi", mosi2, 0);
        chk("rst_cs_n", csn2, 1);
        chk("rst_ready_h1", ready1, 1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("idle_after_release", ready2, 1);

        xfer(8'hA5, 8'h0F, 0, 1'b0, 0, 0);
        xfer(8'h3C, 8'h00, 1, 1'b1, 0, 0);
        xfer(8'hC3, 8'h00, 1, 1'b0, 0, 0);
        xfer(8'h5A, 8'h96, 0, 1'b0, 10, 0);
        xfer(8'h81, 8'h00, 0, 1'b0, 0, 8 * H2 + 1);
        xfer(8'h81, 8'h7E, 0, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            ch = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), ch, 0, 0);
        end

        chk("h1_ready", ready1, 1);
        dv1 = 1'b1;
        din1 = 8'h01;
        tick();
        dv1 = 1'b0;
        chk("h1_mosi_msb", mosi1, 0);
        n1 = 0; hi1 = 0; rise1 = 0; p1 = 1'b0;
        while (n1 < 22 && !dvo1) begin
            tick();
            n1++;
            if (sclk1 && !p1) rise1++;
            if (sclk1) hi1++;
            p1 = sclk1;
        end
        chk("h1_latency", n1, 18);
        chk("h1_data_miso", dout1, 8'hFF);
        chk("h1_sclk_rises", rise1, 8);
        chk("h1_sclk_high_cycles", hi1, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
